// File: rtl/diag_initiator_pkg.sv
// Shared EBUS diagnostic definitions: opcode encoding, function codes,
// FSM/phase encodings and the per-step decode used by the initiator.
// Pure definitions; no timing or flow control of its own.
package diag_initiator_pkg;

   // Command opcodes as presented on cmd_op.
   typedef enum logic [1:0] {
      OP_CTL   = 2'd0,   // control function, 00x
      OP_LD    = 2'd1,   // load function, 04x
      OP_READ  = 2'd2,   // diagnostic read, 10x
      OP_BURST = 2'd3    // three-step burst macro
   } op_t;

   // CTL (00x) function codes.
   localparam logic [2:0] CTL_START       = 3'd1;
   localparam logic [2:0] CTL_SINGLE_STEP = 3'd2;
   localparam logic [2:0] CTL_EBOX_SS     = 3'd3;
   localparam logic [2:0] CTL_COND_SS     = 3'd4;
   localparam logic [2:0] CTL_BURST       = 3'd5;
   localparam logic [2:0] CTL_CLR_RESET   = 3'd6;
   localparam logic [2:0] CTL_SET_RESET   = 3'd7;

   // LD (04x) function codes, 042..047.
   localparam logic [2:0] LD_042 = 3'd2;   // burst count, low nibble
   localparam logic [2:0] LD_043 = 3'd3;   // burst count, high nibble
   localparam logic [2:0] LD_044 = 3'd4;
   localparam logic [2:0] LD_045 = 3'd5;
   localparam logic [2:0] LD_046 = 3'd6;
   localparam logic [2:0] LD_047 = 3'd7;

   // Index of the final step of a BURST macro.
   localparam logic [1:0] BURST_LAST_STEP = 2'd2;

   // Top-level sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   // Phases tracked by the single-step timer.
   typedef enum logic [1:0] {
      PH_IDLE   = 2'd0,
      PH_SETUP  = 2'd1,
      PH_STROBE = 2'd2,
      PH_HOLD   = 2'd3
   } phase_t;

   // What one bus step puts on the EBUS: which strobe, ds[4:6], data[32:35].
   typedef struct packed {
      op_t        op;
      logic [2:0] ds;
      logic [3:0] dat;
   } step_t;

   // Decode a command plus step index into the bus step to issue.
   // EBUS bits [4:7] of cmd_data are the low nibble (bit 0 is the MSB).
   // CTL and READ steps carry no data, so DIAG_DATA is driven to 0 for them.
   function automatic step_t step_cfg(input op_t        op,
                                      input logic [1:0] step,
                                      input logic [2:0] func,
                                      input logic [7:0] data);
      step_t s;
      s.op  = op;
      s.ds  = func;
      s.dat = 4'd0;
      if (op == OP_LD) begin
         s.dat = data[3:0];
      end else if (op == OP_BURST) begin
         case (step)
            2'd0: begin
               s.op  = OP_LD;
               s.ds  = LD_042;
               s.dat = data[3:0];
            end
            2'd1: begin
               s.op  = OP_LD;
               s.ds  = LD_043;
               s.dat = data[7:4];
            end
            default: begin
               s.op  = OP_CTL;
               s.ds  = CTL_BURST;
               s.dat = 4'd0;
            end
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/diag_initiator_step.sv
// Single EBUS step timer: SETUP, STROBE and HOLD phases from one 4-bit down-counter.
// Latency: SETUP_CYC+STROBE_CYC+HOLD_CYC cycles from start to the cycle done is high.
// Backpressure: none; a start in the done cycle chains the next step with no gap.
module diag_step
   import diag_initiator_pkg::*;
#(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 8,
   parameter int HOLD_CYC   = 2
) (
   input  logic clk,
   input  logic i_srst_n,
   input  logic i_start,
   output logic o_end,
   output logic o_last_strobe,
   output logic o_done
);

   // Counter reload values: a phase of N cycles counts N-1 down to 0.
   localparam logic [3:0] L_SETUP  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] L_STROBE = 4'(STROBE_CYC - 1);
   localparam logic [3:0] L_HOLD   = 4'(HOLD_CYC - 1);

   phase_t     r_phase;
   logic [3:0] r_cnt;
   logic       w_zero;

   assign w_zero        = (r_cnt == 4'd0);
   assign o_end         = (r_phase != PH_IDLE) && w_zero;
   assign o_last_strobe = (r_phase == PH_STROBE) && w_zero;
   assign o_done        = (r_phase == PH_HOLD) && w_zero;

   // Step through the phases, reloading the counter at each phase boundary.
   always_ff @(posedge clk) begin
      if (!i_srst_n) begin
         r_phase <= PH_IDLE;
         r_cnt   <= 4'd0;
      end else if (i_start) begin
         r_phase <= PH_SETUP;
         r_cnt   <= L_SETUP;
      end else if (r_phase != PH_IDLE) begin
         if (w_zero) begin
            case (r_phase)
               PH_SETUP: begin
                  r_phase <= PH_STROBE;
                  r_cnt   <= L_STROBE;
               end
               PH_STROBE: begin
                  r_phase <= PH_HOLD;
                  r_cnt   <= L_HOLD;
               end
               default: begin
                  r_phase <= PH_IDLE;
                  r_cnt   <= 4'd0;
               end
            endcase
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

endmodule

// File: rtl/diag_initiator.sv
// EBUS diagnostic initiator: issues CTL/LD/READ function strobes and the 3-step BURST macro.
// Latency: 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles accept to rsp_valid (x3 steps for BURST).
// Backpressure: cmd_ready only in IDLE with no response pending; rsp held until rsp_ready.
module diag_initiator
   import diag_initiator_pkg::*;
#(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 8,
   parameter int HOLD_CYC   = 2
) (
   input  logic       clk,
   input  logic       FPGA_RESET_N,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [2:0] cmd_func,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [5:0] rsp_data,
   output logic       busy,
   output logic [2:0] DIAG_DS,
   output logic [3:0] DIAG_DATA,
   output logic       DIAG_CTL_FUNC_00x,
   output logic       DIAG_LD_FUNC_04x,
   output logic       DIAG_READ_FUNC_10x,
   input  logic [5:0] EBUS_DATA_IN
);

   state_t     r_state;
   op_t        r_op;        // command opcode as accepted
   op_t        r_step_op;   // strobe selected for the step in flight
   logic [2:0] r_func;
   logic [7:0] r_data;
   logic [1:0] r_step;      // BURST progress; stays 0 for single-step ops
   logic [2:0] r_ds;
   logic [3:0] r_dat;
   logic       r_ctl_stb;
   logic       r_ld_stb;
   logic       r_rd_stb;
   logic       r_rsp_valid;
   logic [5:0] r_rsp_data;

   logic       w_accept;
   logic       w_more;
   logic       w_step_start;
   logic       w_step_end;
   logic       w_last_strobe;
   logic       w_step_done;
   step_t      w_first;
   step_t      w_next;

   assign cmd_ready = (r_state == ST_IDLE) && !r_rsp_valid && FPGA_RESET_N;
   assign w_accept  = cmd_valid && cmd_ready;

   // Another burst step follows the current one.
   assign w_more = (r_op == OP_BURST) && (r_step != BURST_LAST_STEP);

   // Kick the step timer on accept and when a burst chains into its next step.
   assign w_step_start = w_accept || ((r_state == ST_HOLD) && w_step_done && w_more);

   // Bus step for a fresh command, and for the next burst step.
   assign w_first = step_cfg(op_t'(cmd_op), 2'd0, cmd_func, cmd_data);
   assign w_next  = step_cfg(r_op, r_step + 2'd1, r_func, r_data);

   assign rsp_valid          = r_rsp_valid;
   assign rsp_data           = r_rsp_data;
   assign busy               = (r_state != ST_IDLE);
   assign DIAG_DS            = r_ds;
   assign DIAG_DATA          = r_dat;
   assign DIAG_CTL_FUNC_00x  = r_ctl_stb;
   assign DIAG_LD_FUNC_04x   = r_ld_stb;
   assign DIAG_READ_FUNC_10x = r_rd_stb;

   diag_step #(
      .SETUP_CYC  (SETUP_CYC),
      .STROBE_CYC (STROBE_CYC),
      .HOLD_CYC   (HOLD_CYC)
   ) u_step (
      .clk           (clk),
      .i_srst_n      (FPGA_RESET_N),
      .i_start       (w_step_start),
      .o_end         (w_step_end),
      .o_last_strobe (w_last_strobe),
      .o_done        (w_step_done)
   );

   // Command sequencing FSM; all EBUS outputs and the response are registered here.
   always_ff @(posedge clk) begin
      if (!FPGA_RESET_N) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_CTL;
         r_step_op   <= OP_CTL;
         r_func      <= 3'd0;
         r_data      <= 8'd0;
         r_step      <= 2'd0;
         r_ds        <= 3'd0;
         r_dat       <= 4'd0;
         r_ctl_stb   <= 1'b0;
         r_ld_stb    <= 1'b0;
         r_rd_stb    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 6'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op       <= op_t'(cmd_op);
                  r_func     <= cmd_func;
                  r_data     <= cmd_data;
                  r_step     <= 2'd0;
                  r_step_op  <= w_first.op;
                  r_ds       <= w_first.ds;
                  r_dat      <= w_first.dat;
                  r_rsp_data <= 6'd0;
                  r_state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_step_end) begin
                  r_ctl_stb <= (r_step_op == OP_CTL);
                  r_ld_stb  <= (r_step_op == OP_LD);
                  r_rd_stb  <= (r_step_op == OP_READ);
                  r_state   <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               // The responder's data is valid by the end of the strobe.
               if (w_last_strobe && (r_step_op == OP_READ)) begin
                  r_rsp_data <= EBUS_DATA_IN;
               end
               if (w_step_end) begin
                  r_ctl_stb <= 1'b0;
                  r_ld_stb  <= 1'b0;
                  r_rd_stb  <= 1'b0;
                  r_state   <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_step_done) begin
                  if (w_more) begin
                     r_step    <= r_step + 2'd1;
                     r_step_op <= w_next.op;
                     r_ds      <= w_next.ds;
                     r_dat     <= w_next.dat;
                     r_state   <= ST_SETUP;
                  end else begin
                     r_step      <= 2'd0;
                     r_ds        <= 3'd0;
                     r_dat       <= 4'd0;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_data  <= 6'd0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_diag_initiator.sv
// Self-checking bench for diag_initiator against a step-list reference model.
// Latency: checks accept-to-response timing per command.
// Backpressure: exercises response stalls and commands offered while busy.
module tb_diag_initiator;

   localparam int S = 2;
   localparam int T = 8;
   localparam int H = 2;
   localparam int P = S + T + H;

   logic       clk = 1'b0;
   logic       FPGA_RESET_N;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [2:0] cmd_func;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [5:0] rsp_data;
   logic       busy;
   logic [2:0] DIAG_DS;
   logic [3:0] DIAG_DATA;
   logic       DIAG_CTL_FUNC_00x;
   logic       DIAG_LD_FUNC_04x;
   logic       DIAG_READ_FUNC_10x;
   logic [5:0] EBUS_DATA_IN;

   logic [2:0] w_stb;
   assign w_stb = {DIAG_CTL_FUNC_00x, DIAG_LD_FUNC_04x, DIAG_READ_FUNC_10x};

   int checks = 0;
   int errors = 0;

   diag_initiator #(
      .SETUP_CYC  (S),
      .STROBE_CYC (T),
      .HOLD_CYC   (H)
   ) dut (
      .clk                (clk),
      .FPGA_RESET_N       (FPGA_RESET_N),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_op             (cmd_op),
      .cmd_func           (cmd_func),
      .cmd_data           (cmd_data),
      .rsp_valid          (rsp_valid),
      .rsp_ready          (rsp_ready),
      .rsp_data           (rsp_data),
      .busy               (busy),
      .DIAG_DS            (DIAG_DS),
      .DIAG_DATA          (DIAG_DATA),
      .DIAG_CTL_FUNC_00x  (DIAG_CTL_FUNC_00x),
      .DIAG_LD_FUNC_04x   (DIAG_LD_FUNC_04x),
      .DIAG_READ_FUNC_10x (DIAG_READ_FUNC_10x),
      .EBUS_DATA_IN       (EBUS_DATA_IN)
   );

   always #5 clk = ~clk;

   // Reference model: the list of bus steps a command should produce.
   int         m_n;
   logic [1:0] m_op  [3];
   logic [2:0] m_ds  [3];
   logic [3:0] m_dat [3];

   function automatic logic [2:0] stb_code(input logic [1:0] op);
      case (op)
         2'd0:    return 3'b100;
         2'd1:    return 3'b010;
         2'd2:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic model_build(input logic [1:0] op, input logic [2:0] func, input logic [7:0] data);
      if (op == 2'd3) begin
         m_n = 3;
         m_op[0] = 2'd1; m_ds[0] = 3'd2; m_dat[0] = data[3:0];
         m_op[1] = 2'd1; m_ds[1] = 3'd3; m_dat[1] = data[7:4];
         m_op[2] = 2'd0; m_ds[2] = 3'd5; m_dat[2] = 4'd0;
      end else begin
         m_n = 1;
         m_op[0]  = op;
         m_ds[0]  = func;
         m_dat[0] = (op == 2'd1) ? data[3:0] : 4'd0;
      end
   endtask

   task automatic scramble_cmd();
      cmd_valid = 1'($urandom);
      cmd_op    = 2'($urandom);
      cmd_func  = 3'($urandom);
      cmd_data  = 8'($urandom);
   endtask

   // Issue one command, follow it cycle by cycle, then consume the response.
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] func, input logic [7:0] data,
                          input logic [5:0] ebus, input int rsp_delay, input string name);
      int n, lat, bad, first_bad, stb_cycles, stall_bad, ncap, k, r;
      logic [2:0] e_stb, e_ds, f_stb, f_ds, f_estb, f_eds;
      logic [3:0] e_dat, f_dat, f_edat;
      logic [5:0] e_rsp;
      bit done;
      model_build(op, func, data);
      e_rsp = (op == 2'd2) ? ebus : 6'd0;
      ncap  = (m_n - 1) * P + S + T;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_func = func; cmd_data = data;
      EBUS_DATA_IN = 6'($urandom);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s accept: cmd_ready=%b required 1", name, cmd_ready);
      end
      @(negedge clk);
      n = 1; bad = 0; first_bad = 0; stb_cycles = 0; done = 0; lat = 0;
      f_stb = 0; f_ds = 0; f_dat = 0; f_estb = 0; f_eds = 0; f_edat = 0;
      while (!done && n <= 3 * P + 8) begin
         if (rsp_valid === 1'b1) begin
            done = 1;
            lat  = n;
         end else begin
            k = (n - 1) / P;
            r = (n - 1) % P;
            if (k < m_n) begin
               e_stb = (r >= S && r < S + T) ? stb_code(m_op[k]) : 3'b000;
               e_ds  = m_ds[k];
               e_dat = m_dat[k];
            end else begin
               e_stb = 3'b000; e_ds = 3'd0; e_dat = 4'd0;
            end
            if (w_stb !== 3'b000) stb_cycles++;
            if (w_stb !== e_stb || DIAG_DS !== e_ds || DIAG_DATA !== e_dat ||
                busy !== 1'b1 || cmd_ready !== 1'b0) begin
               if (bad == 0) begin
                  first_bad = n;
                  f_stb = w_stb; f_ds = DIAG_DS; f_dat = DIAG_DATA;
                  f_estb = e_stb; f_eds = e_ds; f_edat = e_dat;
               end
               bad++;
            end
            scramble_cmd();
            EBUS_DATA_IN = (n == ncap) ? ebus : (ebus ^ 6'($urandom_range(1, 63)));
            @(negedge clk);
            n++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s trace: %0d bad cycles, first cycle %0d stb=%b ds=%0o data=%h busy/ready, required stb=%b ds=%0o data=%h",
                  name, bad, first_bad, f_stb, f_ds, f_dat, f_estb, f_eds, f_edat);
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s latency: no rsp_valid within %0d cycles, required %0d", name, 3 * P + 8, 1 + m_n * P);
         cmd_valid = 1'b0;
         return;
      end else if (lat != 1 + m_n * P) begin
         errors++;
         $display("FAIL %s latency: %0d cycles, required %0d", name, lat, 1 + m_n * P);
      end
      checks++;
      if (stb_cycles != m_n * T) begin
         errors++;
         $display("FAIL %s strobe_cycles: %0d, required %0d", name, stb_cycles, m_n * T);
      end
      checks++;
      if (rsp_data !== e_rsp) begin
         errors++;
         $display("FAIL %s rsp_data: %b, required %b", name, rsp_data, e_rsp);
      end
      cmd_valid = 1'b0;
      stall_bad = 0;
      for (int d = 0; d < rsp_delay; d++) begin
         rsp_ready = 1'b0;
         scramble_cmd();
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_data !== e_rsp || cmd_ready !== 1'b0 || busy !== 1'b1) stall_bad++;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      if (rsp_delay > 0) begin
         checks++;
         if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s stall: %0d unstable cycles of %0d, required 0", name, stall_bad, rsp_delay);
         end
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
          DIAG_DS !== 3'd0 || DIAG_DATA !== 4'd0 || w_stb !== 3'b000) begin
         errors++;
         $display("FAIL %s release: rsp_valid=%b busy=%b cmd_ready=%b ds=%0o data=%h stb=%b, required 0 0 1 0 0 000",
                  name, rsp_valid, busy, cmd_ready, DIAG_DS, DIAG_DATA, w_stb);
      end
   endtask

   task automatic test_reset();
      FPGA_RESET_N = 1'b0;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_func = 3'd0; cmd_data = 8'd0;
      rsp_ready = 1'b0; EBUS_DATA_IN = 6'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (w_stb !== 3'b000 || DIAG_DS !== 3'd0 || DIAG_DATA !== 4'd0 || rsp_valid !== 1'b0 ||
          rsp_data !== 6'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: stb=%b ds=%0o data=%h rsp_valid=%b rsp_data=%b busy=%b cmd_ready=%b, required all 0",
                  w_stb, DIAG_DS, DIAG_DATA, rsp_valid, rsp_data, busy, cmd_ready);
      end
      FPGA_RESET_N = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_ctl_start();
      run_cmd(2'd0, 3'd1, 8'($urandom), 6'($urandom), 0, "ctl_start");
   endtask

   task automatic test_read();
      run_cmd(2'd2, 3'd6, 8'($urandom), 6'b101101, 1, "read");
   endtask

   task automatic test_burst();
      run_cmd(2'd3, 3'($urandom), 8'hA5, 6'($urandom), 2, "burst_a5");
   endtask

   task automatic test_backpressure();
      run_cmd(2'd2, 3'($urandom), 8'($urandom), 6'($urandom), 20, "stall20");
      run_cmd(2'd1, 3'($urandom), 8'($urandom), 6'($urandom), 0, "after_stall");
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_cmd(2'($urandom), 3'($urandom), 8'($urandom), 6'($urandom), $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_back_to_back();
      run_cmd(2'd1, 3'd0, 8'($urandom), 6'($urandom), 0, "b2b_ld0");
      run_cmd(2'd0, 3'd0, 8'($urandom), 6'($urandom), 0, "b2b_ctl0");
      run_cmd(2'd3, 3'($urandom), 8'($urandom), 6'($urandom), 0, "b2b_burst");
   endtask

   task automatic test_reset_mid();
      int viol;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_func = 3'd4; cmd_data = 8'($urandom);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid accept: cmd_ready=%b required 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (S + 3) @(negedge clk);
      checks++;
      if (DIAG_LD_FUNC_04x !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid strobe_before: ld=%b required 1", DIAG_LD_FUNC_04x);
      end
      FPGA_RESET_N = 1'b0;
      @(negedge clk);
      checks++;
      if (w_stb !== 3'b000 || busy !== 1'b0 || DIAG_DS !== 3'd0 || DIAG_DATA !== 4'd0 ||
          rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid after_edge: stb=%b busy=%b ds=%0o data=%h rsp_valid=%b cmd_ready=%b, required all 0",
                  w_stb, busy, DIAG_DS, DIAG_DATA, rsp_valid, cmd_ready);
      end
      FPGA_RESET_N = 1'b1;
      viol = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || w_stb !== 3'b000 || busy !== 1'b0) viol++;
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL rst_mid no_response: %0d active cycles after release, required 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_ctl_start();
      test_read();
      test_burst();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      run_cmd(2'd0, 3'd7, 8'($urandom), 6'($urandom), 1, "post_reset");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/diag_initiator.md
DIAG_INITIATOR -- requirements
Module: diag_initiator

Interface
REQ-001 SHALL have parameters SETUP_CYC (default 2), cycles DS/DATA are stable before the strobe.
REQ-002 SHALL have parameters STROBE_CYC (default 8), cycles a function strobe is asserted, and HOLD_CYC (default 2), cycles DS/DATA are held after the strobe; each is 1..15.
REQ-003 Ports, clock and reset first:
  clk  in  1  single clock; all logic on posedge.
  FPGA_RESET_N  in  1  synchronous, active-low reset.
  cmd_valid  in  1  command offered.
  cmd_ready  out  1  command accepted when valid&ready.
  cmd_op  in  2  0=CTL (00x), 1=LD (04x), 2=READ (10x), 3=BURST macro.
  cmd_func  in  3  function select, EBUS ds[4:6].
  cmd_data  in  8  LD uses [4:7] as data[32:35]; BURST uses all 8 as the count.
  rsp_valid  out  1  response pending.
  rsp_ready  in  1  response consumed when valid&ready.
  rsp_data  out  6  READ result (data[30:35]); 0 for other ops.
  busy  out  1  high in any non-IDLE state.
  DIAG_DS  out  3  EBUS ds[4:6].
  DIAG_DATA  out  4  EBUS data[32:35].
  DIAG_CTL_FUNC_00x  out  1  control-function strobe.
  DIAG_LD_FUNC_04x  out  1  load-function strobe.
  DIAG_READ_FUNC_10x  out  1  diag-read strobe.
  EBUS_DATA_IN  in  6  EBUS data[30:35] returned by the responder.

Function
REQ-004 FSM states SHALL be IDLE, SETUP, STROBE, HOLD, RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE with rsp_valid=0.
REQ-006 On accept, SHALL latch op/func/data, drive DIAG_DS/DIAG_DATA next cycle, and enter SETUP.
REQ-007 SETUP SHALL last SETUP_CYC cycles, STROBE STROBE_CYC, and HOLD HOLD_CYC, timed by one 4-bit down-counter.
REQ-008 During STROBE, exactly one strobe SHALL be high, selected by the current step's op; all strobes SHALL be 0 in every other state.
REQ-009 DIAG_DS/DIAG_DATA SHALL stay constant from SETUP entry through HOLD exit; they SHALL be 0 in IDLE.
REQ-010 READ SHALL capture EBUS_DATA_IN on the last STROBE cycle into rsp_data.
REQ-011 After HOLD of the final step, the FSM SHALL enter RESP with rsp_valid=1 and hold rsp_data stable until rsp_ready, then return to IDLE.
REQ-012 If rsp_ready=1 on the first RESP cycle, the FSM SHALL return to IDLE on the next edge (1-cycle response).
REQ-013 Minimum command latency, accept to rsp_valid, SHALL be 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
REQ-014 BURST SHALL run three full SETUP/STROBE/HOLD steps back-to-back with no IDLE between:
  LD func 2 with cmd_data[4:7] (count LSB);
  LD func 3 with cmd_data[0:3] (count MSB);
  CTL func 5 (burst start).
  It SHALL produce one response, with rsp_data=0.
REQ-015 A 2-bit step counter SHALL track BURST progress; for non-BURST ops it SHALL stay 0.
REQ-016 CTL func 0 and LD funcs 0/1 SHALL still be issued as commanded; no opcode checking.
REQ-017 cmd_valid while busy SHALL be ignored with cmd_ready=0; inputs are not sampled.

Reset
REQ-018 While FPGA_RESET_N=0 at a clock edge, the FSM SHALL go to IDLE and these outputs SHALL be 0: all strobes, DIAG_DS, DIAG_DATA, rsp_valid, rsp_data, busy, counters. cmd_ready is 0 while reset is asserted.
REQ-019 Reset mid-operation SHALL drop any strobe at that edge, discard the command, and produce no response.

Structure
REQ-020 The op encoding enum, the CTL function codes (START=1, SINGLE_STEP=2, EBOX_SS=3, COND_SS=4, BURST=5, CLR_RESET=6, SET_RESET=7), and the LD codes (042..047 as 2..7) SHALL live in the shared EBOX package/header.
REQ-021 One sub-module, diag_step, SHALL implement the single SETUP/STROBE/HOLD step timer (start in, done out); the top-level FSM sequences steps and handshakes.

Verification
REQ-022 CTL func 1 with defaults: DIAG_CTL_FUNC_00x high for exactly 8 cycles; DIAG_DS=3'b001 from 2 cycles before the strobe until 2 cycles after; rsp_valid 13 cycles after accept with rsp_data=0.
REQ-023 READ func 6 with EBUS_DATA_IN=6'b101101 on the last strobe cycle (changing to 0 afterward): rsp_data=6'b101101.
REQ-024 BURST with cmd_data=8'hA5: three strobes in order — LD/ds=2/data=5, then LD/ds=3/data=A, then CTL/ds=5 — one response, 37 cycles accept to rsp_valid.
REQ-025 rsp_ready held 0 for 20 cycles: rsp_valid and rsp_data are stable, cmd_ready=0, and a cmd_valid pulse is not accepted; after rsp_ready, the next command is accepted.
REQ-026 FPGA_RESET_N=0 during the 4th STROBE cycle of LD func 4: the strobe is 0 the next cycle, and no rsp_valid follows after reset is released.
